// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - MSB-first square-and-multiply modular exponentiation controller
//
// Computes msg_out = (msg_in ^ key) mod mod by driving an external modular
// multiplier through a req/ack handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             begin one exponentiation (accepted only when idle)
//   msg_in, key, mod  base, exponent and modulus, latched on accepted start
//   busy              high from the cycle after accepted start through done
//   done              one-cycle completion pulse
//   err               modulus was zero; held until the next accepted start
//   msg_out           registered result, held between done pulses
//   mm_req            multiplier request, held until mm_ack is sampled
//   mm_a, mm_b, mm_m  multiplier operands and modulus
//   mm_ack, mm_res    multiplier completion strobe and (mm_a*mm_b) mod mm_m
module modexp_ctrl #(
   parameter int WIDTH   = 16,
   parameter int KEYSIZE = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   msg_in,
   input  logic [KEYSIZE-1:0] key,
   input  logic [WIDTH-1:0]   mod,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [WIDTH-1:0]   msg_out,
   output logic               mm_req,
   output logic [WIDTH-1:0]   mm_a,
   output logic [WIDTH-1:0]   mm_b,
   output logic [WIDTH-1:0]   mm_m,
   input  logic               mm_ack,
   input  logic [WIDTH-1:0]   mm_res
);

   localparam int               IW      = (KEYSIZE > 1) ? $clog2(KEYSIZE) : 1;
   localparam logic [IW-1:0]    IDX_TOP = IW'(KEYSIZE - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, SCAN, MUL_REQ, SQR_REQ, NEXT, FINISH
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   base_q, base_d;
   logic [KEYSIZE-1:0] key_q, key_d;
   logic [WIDTH-1:0]   mod_q, mod_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic               seen_q, seen_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   msg_out_q, msg_out_d;
   logic               mm_req_q, mm_req_d;
   logic [WIDTH-1:0]   mm_a_q, mm_a_d;
   logic [WIDTH-1:0]   mm_b_q, mm_b_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         key_q     <= '0;
         mod_q     <= '0;
         idx_q     <= IDX_TOP;
         acc_q     <= ONE;
         seen_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         msg_out_q <= '0;
         mm_req_q  <= 1'b0;
         mm_a_q    <= '0;
         mm_b_q    <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         key_q     <= key_d;
         mod_q     <= mod_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         seen_q    <= seen_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         msg_out_q <= msg_out_d;
         mm_req_q  <= mm_req_d;
         mm_a_q    <= mm_a_d;
         mm_b_q    <= mm_b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      key_d     = key_q;
      mod_d     = mod_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      seen_d    = seen_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      msg_out_d = msg_out_q;
      mm_req_d  = mm_req_q;
      mm_a_d    = mm_a_q;
      mm_b_d    = mm_b_q;

      case (state_q)
         IDLE: begin
            // busy is still high here during the done cycle; it drops next.
            busy_d = 1'b0;
            if (start) begin
               base_d  = msg_in;
               key_d   = key;
               mod_d   = mod;
               err_d   = 1'b0;
               idx_d   = IDX_TOP;
               acc_d   = ONE;
               seen_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (mod_q == '0) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else if (key_q == '0) begin
               state_d = FINISH;
            end else if (!seen_q) begin
               // Leading zeros are skipped here one per cycle; a set bit
               // exists, so the index cannot underflow.
               if (key_q[idx_q]) begin
                  seen_d  = 1'b1;
                  state_d = MUL_REQ;
               end else begin
                  idx_d = idx_q - IW'(1);
               end
            end else begin
               state_d = SQR_REQ;
            end
         end
         // Each request state first raises mm_req with operands taken from
         // the current acc, then waits for the ack. Entering with mm_req low
         // guarantees a low cycle between back-to-back transactions.
         MUL_REQ: begin
            if (!mm_req_q) begin
               mm_req_d = 1'b1;
               mm_a_d   = acc_q;
               mm_b_d   = base_q;
            end else if (mm_ack) begin
               acc_d    = mm_res;
               mm_req_d = 1'b0;
               state_d  = NEXT;
            end
         end
         SQR_REQ: begin
            if (!mm_req_q) begin
               mm_req_d = 1'b1;
               mm_a_d   = acc_q;
               mm_b_d   = acc_q;
            end else if (mm_ack) begin
               acc_d    = mm_res;
               mm_req_d = 1'b0;
               state_d  = key_q[idx_q] ? MUL_REQ : NEXT;
            end
         end
         NEXT: begin
            if (idx_q == '0) begin
               state_d = FINISH;
            end else begin
               idx_d   = idx_q - IW'(1);
               state_d = SCAN;
            end
         end
         FINISH: begin
            // acc starts at 1, so a zero key with mod==1 must be forced to 0.
            msg_out_d = (err_q || mod_q == ONE) ? '0 : acc_q;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign msg_out = msg_out_q;
   assign mm_req  = mm_req_q;
   assign mm_a    = mm_a_q;
   assign mm_b    = mm_b_q;
   assign mm_m    = mod_q;

endmodule
